board_init_shuffler: RTL and testbench

- Upstream stage of the in-game FSM. Builds a fresh shuffled 4x4 memory board: 8 tile IDs, each used twice, placed in 16 slots.
- Writes all 16 tile bytes into the shared tile RAM through its write port, then pulses done. Top-level control uses done to raise inGameOn.
- Tile byte format shared with the in-game FSM: [7:2] tile ID, [1] flipped, [0] cursor. Slot 0 starts with the cursor.

---
 rtl/board_init_shuffler.sv | 183 ++++++++++++++++++
 tb/tb_board_init_shuffler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_init_shuffler.sv
`timescale 1ns/1ps
// board_init_shuffler
//
// Purpose: builds a fresh 4x4 memory board (8 tile IDs, each placed twice) by
// filling an ordered ID array, shuffling it with a Fisher-Yates walk driven by
// a free-running 16-bit Galois LFSR, then streaming all 16 tile bytes into the
// shared tile RAM and pulsing done.
//
// Tile byte format: [7:2] tile ID (zero-extended), [1] flipped, [0] cursor.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   start       level input; a rising edge requests a new board (IDLE only)
//   busy        high from accepted start until done
//   done        one-cycle pulse after the last RAM write
//   ram_addr    tile RAM address (holds its last value outside WRITE)
//   ram_wdata   tile RAM write data (holds its last value outside WRITE)
//   ram_we      tile RAM write enable, one write per cycle during WRITE
//   lfsr_state  current LFSR value (debug)
//
// Optional build macro: DETERMINISTIC_BOARD_EN
//   defined   -> shuffle is skipped, slot k holds ID k>>1 (18-cycle latency)
//   undefined -> full LFSR shuffle
//
// State table:
//   S_IDLE    | waiting for a start rising edge
//   S_FILL    | load arr[k] = k>>1, i = 15, rej = 0
//   S_SHUFFLE | one draw per cycle, swap arr[i] with arr[lfsr[3:0]]
//   S_WRITE   | write slot k (0..15) to the tile RAM
//   S_DONE    | one-cycle done pulse

module board_init_shuffler #(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          REJECT_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic [15:0] lfsr_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_SHUFFLE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [2:0]  REJ_MAX  = 3'(REJECT_LIMIT - 1);

  state_t      state, state_nxt;
  logic [15:0] lfsr, lfsr_nxt;
  logic        start_prev;
  logic        start_pulse;
  logic [2:0]  arr [16];
  logic [3:0]  i;
  logic [2:0]  rej;
  logic [3:0]  k;
  logic [3:0]  addr_q;
  logic [7:0]  wdata_q;

  logic [3:0]  r;
  logic        accept;
  logic        fallback;
  logic        draw_done;
  logic [7:0]  wdata_cur;

  assign lfsr_nxt    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign lfsr_state  = lfsr;
  assign start_pulse = start & ~start_prev;

  // Draws above i are rejected; after REJECT_LIMIT consecutive rejects the
  // position is left in place so the walk always advances.
  assign r         = lfsr[3:0];
  assign accept    = (r <= i);
  assign fallback  = !accept && (rej == REJ_MAX);
  assign draw_done = accept || fallback;

  assign wdata_cur = {3'b000, arr[k], 1'b0, (k == 4'd0)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    case (state)
      S_IDLE: begin
        if (start_pulse) state_nxt = S_FILL;
      end
      S_FILL: begin
        busy = 1'b1;
`ifdef DETERMINISTIC_BOARD_EN
        state_nxt = S_WRITE;
`else
        state_nxt = S_SHUFFLE;
`endif
      end
      S_SHUFFLE: begin
        busy = 1'b1;
        if (draw_done && (i == 4'd1)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = k;
        ram_wdata = wdata_cur;
        if (k == 4'd15) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: LFSR runs in every state so idle time between boards varies
  // the shuffle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr       <= SEED_EFF;
      start_prev <= 1'b0;
      i          <= 4'd0;
      rej        <= 3'd0;
      k          <= 4'd0;
      addr_q     <= 4'd0;
      wdata_q    <= 8'd0;
      for (int n = 0; n < 16; n++) arr[n] <= 3'd0;
    end else begin
      lfsr       <= lfsr_nxt;
      start_prev <= start;
      case (state)
        S_FILL: begin
          for (int n = 0; n < 16; n++) arr[n] <= 3'(n >> 1);
          i   <= 4'd15;
          rej <= 3'd0;
          k   <= 4'd0;
        end
        S_SHUFFLE: begin
          if (accept) begin
            arr[i] <= arr[r];
            arr[r] <= arr[i];
            rej    <= 3'd0;
          end else if (fallback) begin
            rej <= 3'd0;
          end else begin
            rej <= rej + 3'd1;
          end
          if (draw_done) begin
            if (i == 4'd1) k <= 4'd0;
            else           i <= i - 4'd1;
          end
        end
        S_WRITE: begin
          addr_q  <= k;
          wdata_q <= wdata_cur;
          if (k != 4'd15) k <= k + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_init_shuffler.sv
`timescale 1ns/1ps
// tb_board_init_shuffler
//
// Purpose: directed self-checking bench for board_init_shuffler. Instantiates
// a default-parameter unit (u0), a fallback unit with SEED=1 and
// REJECT_LIMIT=1 (u1), and a zero-seed unit (uz). Expected values are
// hand-computed constants (LFSR steps, ordered board bytes, latencies) plus
// board invariants collected by a write monitor.
// Honors DETERMINISTIC_BOARD_EN the same way the design does.

module tb_board_init_shuffler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start_fb, start_z;

  logic        busy, done, ram_we;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [15:0] lfsr_state;

  logic        fb_busy, fb_done, fb_ram_we;
  logic [3:0]  fb_ram_addr;
  logic [7:0]  fb_ram_wdata;
  logic [15:0] fb_lfsr_state;

  logic        z_busy, z_done, z_ram_we;
  logic [3:0]  z_ram_addr;
  logic [7:0]  z_ram_wdata;
  logic [15:0] z_lfsr_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  board_init_shuffler u_dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .lfsr_state(lfsr_state)
  );

  board_init_shuffler #(.SEED(16'h0001), .REJECT_LIMIT(1)) u_fb (
    .clk(clk), .reset(reset), .start(start_fb),
    .busy(fb_busy), .done(fb_done), .ram_addr(fb_ram_addr), .ram_wdata(fb_ram_wdata),
    .ram_we(fb_ram_we), .lfsr_state(fb_lfsr_state)
  );

  board_init_shuffler #(.SEED(16'h0000)) u_z (
    .clk(clk), .reset(reset), .start(start_z),
    .busy(z_busy), .done(z_done), .ram_addr(z_ram_addr), .ram_wdata(z_ram_wdata),
    .ram_we(z_ram_we), .lfsr_state(z_lfsr_state)
  );

  // Ordered board bytes: ID k>>1 in [7:2], cursor only at slot 0.
  logic [7:0] ordered [16] = '{8'h01, 8'h00, 8'h04, 8'h04, 8'h08, 8'h08, 8'h0C, 8'h0C,
                               8'h10, 8'h10, 8'h14, 8'h14, 8'h18, 8'h18, 8'h1C, 8'h1C};

  // Write monitor state, one set per observed unit.
  int         wr_cnt    [2];
  int         dup_cnt   [2];
  int         order_bad [2];
  int         we_runs   [2];
  int         flip_bad  [2];
  int         cur_bad   [2];
  int         hi_bad    [2];
  int         done_cnt  [2];
  int         id_cnt    [2][8];
  logic [15:0] addr_seen[2];
  logic [3:0] next_addr [2];
  logic       prev_we   [2];
  logic [7:0] wlog      [2][16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon(input int u);
    wr_cnt[u]    = 0;
    dup_cnt[u]   = 0;
    order_bad[u] = 0;
    we_runs[u]   = 0;
    flip_bad[u]  = 0;
    cur_bad[u]   = 0;
    hi_bad[u]    = 0;
    done_cnt[u]  = 0;
    addr_seen[u] = 16'h0000;
    next_addr[u] = 4'd0;
    for (int n = 0; n < 8; n++) id_cnt[u][n] = 0;
    for (int n = 0; n < 16; n++) wlog[u][n] = 8'hFF;
  endtask

  task automatic mon_sample(input int u, input logic we, input logic [3:0] a,
                            input logic [7:0] d, input logic dn);
    if (we) begin
      wr_cnt[u]++;
      if (addr_seen[u][a]) dup_cnt[u]++;
      addr_seen[u][a] = 1'b1;
      if (a != next_addr[u]) order_bad[u]++;
      next_addr[u] = a + 4'd1;
      id_cnt[u][d[4:2]]++;
      if (d[7:5] != 3'b000) hi_bad[u]++;
      if (d[1]) flip_bad[u]++;
      if (d[0] != (a == 4'd0)) cur_bad[u]++;
      wlog[u][a] = d;
      if (!prev_we[u]) we_runs[u]++;
    end
    if (dn) done_cnt[u]++;
    prev_we[u] = we;
  endtask

  initial begin
    prev_we[0] = 1'b0;
    prev_we[1] = 1'b0;
    clear_mon(0);
    clear_mon(1);
  end

  always @(negedge clk) begin
    mon_sample(0, ram_we, ram_addr, ram_wdata, done);
    mon_sample(1, fb_ram_we, fb_ram_addr, fb_ram_wdata, fb_done);
  end

  function automatic logic done_of(input int u);
    return (u == 0) ? done : fb_done;
  endfunction

  task automatic set_start(input int u, input logic v);
    if (u == 0) start = v;
    else        start_fb = v;
  endtask

  // Raises start at a negedge and counts rising edges until done is seen.
  task automatic run_board(input int u, input int limit, output int lat);
    clear_mon(u);
    @(negedge clk);
    set_start(u, 1'b1);
    lat = 0;
    while (lat < limit + 5) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_of(u)) break;
    end
    @(posedge clk);
    #1;
    check($sformatf("u%0d_done_one_cycle", u), {31'd0, done_of(u)}, 32'd0);
    @(negedge clk);
    set_start(u, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_board(input int u);
    string s;
    s = $sformatf("u%0d", u);
    check({s, "_wr_cnt"},    wr_cnt[u],    32'd16);
    check({s, "_addr_seen"}, {16'd0, addr_seen[u]}, 32'h0000FFFF);
    check({s, "_dup"},       dup_cnt[u],   32'd0);
    check({s, "_order"},     order_bad[u], 32'd0);
    check({s, "_we_runs"},   we_runs[u],   32'd1);
    check({s, "_flip"},      flip_bad[u],  32'd0);
    check({s, "_cursor"},    cur_bad[u],   32'd0);
    check({s, "_id_high"},   hi_bad[u],    32'd0);
    check({s, "_done_cnt"},  done_cnt[u],  32'd1);
    for (int id = 0; id < 8; id++)
      check($sformatf("%s_id%0d_cnt", s, id), id_cnt[u][id], 32'd2);
`ifdef DETERMINISTIC_BOARD_EN
    for (int n = 0; n < 16; n++)
      check($sformatf("%s_ordered_addr%0d", s, n), {24'd0, wlog[u][n]}, {24'd0, ordered[n]});
`endif
  endtask

  initial begin
    int lat;
    int guard;
    reset    = 1'b1;
    start    = 1'b0;
    start_fb = 1'b0;
    start_z  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_lfsr",      {16'd0, lfsr_state},    32'h0000ACE1);
    check("rst_lfsr_fb",   {16'd0, fb_lfsr_state}, 32'h00000001);
    check("rst_lfsr_zero", {16'd0, z_lfsr_state},  32'h00000001);
    check("rst_busy",      {31'd0, busy},   32'd0);
    check("rst_done",      {31'd0, done},   32'd0);
    check("rst_we",        {31'd0, ram_we}, 32'd0);
    check("rst_addr",      {28'd0, ram_addr},  32'd0);
    check("rst_wdata",     {24'd0, ram_wdata}, 32'd0);

    // LFSR steps from ACE1 with mask B400, hand-computed.
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("lfsr_step1",    {16'd0, lfsr_state},    32'h0000E270);
    check("lfsr_fb_step1", {16'd0, fb_lfsr_state}, 32'h0000B400);
    @(posedge clk); #1;
    check("lfsr_step2",    {16'd0, lfsr_state},    32'h00007138);
    repeat (4) @(posedge clk);
    #1;
    check("lfsr_step6",    {16'd0, lfsr_state},    32'h0000B313);
    check("idle_we",       {31'd0, ram_we}, 32'd0);
    check("idle_busy",     {31'd0, busy},   32'd0);

    // Main board.
    run_board(0, 138, lat);
`ifdef DETERMINISTIC_BOARD_EN
    check("u0_latency", lat, 32'd18);
`else
    check("u0_latency_min", {31'd0, lat >= 33},  32'd1);
    check("u0_latency_max", {31'd0, lat <= 138}, 32'd1);
`endif
    check_board(0);
    check("u0_busy_after", {31'd0, busy}, 32'd0);
    check("u0_addr_hold",  {28'd0, ram_addr}, 32'd15);

    // Fallback unit: every draw resolves in one cycle.
    run_board(1, 33, lat);
`ifdef DETERMINISTIC_BOARD_EN
    check("u1_latency", lat, 32'd18);
`else
    check("u1_latency", lat, 32'd33);
`endif
    check_board(1);

    // Start pulse while busy is ignored.
    clear_mon(0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_mid_board", {31'd0, busy}, 32'd1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (160) @(negedge clk);
    check("busy_start_wr_cnt",   wr_cnt[0],   32'd16);
    check("busy_start_done_cnt", done_cnt[0], 32'd1);

    // Start held high for 200 cycles builds one board.
    clear_mon(0);
    @(negedge clk) start = 1'b1;
    repeat (200) @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("held_wr_cnt",   wr_cnt[0],   32'd16);
    check("held_done_cnt", done_cnt[0], 32'd1);

    // Reset on the 5th WRITE cycle.
    clear_mon(0);
    @(negedge clk) start = 1'b1;
    guard = 0;
    while (guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
      if (ram_we && ram_addr == 4'd4) break;
    end
    check("rst_mid_reached_write5", {31'd0, guard < 200}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_we",    {31'd0, ram_we},     32'd0);
    check("rst_mid_busy",  {31'd0, busy},       32'd0);
    check("rst_mid_addr",  {28'd0, ram_addr},   32'd0);
    check("rst_mid_wdata", {24'd0, ram_wdata},  32'd0);
    check("rst_mid_lfsr",  {16'd0, lfsr_state}, 32'h0000ACE1);
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_wr_cnt",   wr_cnt[0],   32'd4);
    check("rst_mid_done_cnt", done_cnt[0], 32'd0);

    run_board(0, 138, lat);
`ifdef DETERMINISTIC_BOARD_EN
    check("after_rst_latency", lat, 32'd18);
`else
    check("after_rst_latency_max", {31'd0, lat <= 138}, 32'd1);
`endif
    check_board(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
